regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning register count (power of two, >= 2).
REQ-003 SHALL have parameter WR_LIMIT, default 4, meaning only addresses 0..WR_LIMIT-1 are writeable (1 <= WR_LIMIT <= NUM_REGS).
REQ-004 SHALL have parameter CNT_W, default 8, meaning width of the commit counter.
REQ-005 SHALL derive localparam AW = clog2(NUM_REGS), the address width.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset: synchronous, active-low.
REQ-008 we  input  1  write request, sampled on rising clk.
REQ-009 waddr  input  AW  write address.
REQ-010 wdata  input  DATA_W  write data.
REQ-011 clr  input  1  synchronous clear of all writeable registers.
REQ-012 err_clr  input  1  clears the sticky write-error flag.
REQ-013 raddr1 / raddr2  input  AW  read addresses, ports 1 and 2.
REQ-014 rdata1 / rdata2  output  DATA_W  combinational read data, ports 1 and 2.
REQ-015 wr_err  output  1  sticky flag: a write to a protected address was attempted.
REQ-016 wr_count  output  CNT_W  saturating count of committed writes.

Function
REQ-017 Legal write (we=1, waddr<WR_LIMIT, clr=0) SHALL load a one-entry staging register (valid, addr, data) at edge t; the array entry SHALL be updated at edge t+1.
REQ-018 Every read port SHALL forward staging data when staging is valid and raddr equals staging addr; otherwise it SHALL return array[raddr]; written data is therefore visible immediately after edge t.
REQ-019 When no new legal write is accepted at edge t+1, staging valid SHALL drop at that edge. Back-to-back writes SHALL sustain one write per cycle.
REQ-020 If consecutive writes target the same address, the later write SHALL win in both forwarding and array contents.
REQ-021 A write with waddr>=WR_LIMIT SHALL NOT load staging or change the array, and SHALL set wr_err at that edge.
REQ-022 wr_err SHALL remain set until err_clr=1 at an edge; if a set condition and err_clr occur in the same cycle, set SHALL win.
REQ-023 clr=1 SHALL zero registers 0..WR_LIMIT-1 and invalidate staging at that edge. A we in the same cycle SHALL be discarded and SHALL NOT count. A pending staged write SHALL NOT commit.
REQ-024 Registers WR_LIMIT..NUM_REGS-1 SHALL read 0 at all times after reset.
REQ-025 wr_count SHALL increment by 1 on each edge where a staged write commits into the array, and SHALL saturate at 2^CNT_W-1.
REQ-026 Reads SHALL have zero-cycle latency; both ports may read the same address simultaneously.

Reset
REQ-027 While rst_n=0 at an edge, all NUM_REGS registers SHALL be set to 0, staging invalidated, wr_err=0 and wr_count=0; resulting outputs are rdata=0 for all addresses, wr_err=0 and wr_count=0.
REQ-028 Reset SHALL take priority over clr, we and err_clr. A write staged before reset SHALL be lost.

Structure
REQ-029 Default parameter values and the AW derivation SHALL live in a shared package/header (regfile_pkg), reused by the bench.
REQ-030 The staging register plus forwarding compare SHALL be a sub-module, regfile_wstage, instantiated once per read port for the compare and once for the store.

Verification
REQ-031 Reset then write reg1=55. Read reg1 on the cycle after the write edge -> 55 via forwarding, and 55 from the array two cycles later. wr_count=1.
REQ-032 Write reg4=100 -> reg4 reads 0, wr_err=1, wr_count unchanged. Assert err_clr with no bad write -> wr_err=0 next cycle.
REQ-033 Back-to-back writes reg3=200 then reg3=300, reading reg3 on both ports each cycle -> 200 then 300, final array 300, wr_count=+2.
REQ-034 Write reg0=7 with clr asserted in the following cycle -> reg0 reads 0, no commit counted. A write in the same cycle as clr is discarded.
REQ-035 Drive rst_n=0 the cycle after a write to reg2=9 -> all reads 0, wr_count=0, wr_err=0.
REQ-036 CNT_W=2: five legal writes -> wr_count saturates at 3. Simultaneous bad write and err_clr -> wr_err=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared defaults and address-width derivation for the parameterised
//   register file. Imported by the RTL and by the testbench so both agree
//   on geometry without repeating literals.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W   = 10;
    localparam int unsigned DEF_NUM_REGS = 8;
    localparam int unsigned DEF_WR_LIMIT = 4;
    localparam int unsigned DEF_CNT_W    = 8;

    // Address width for a register count; never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_AW = addr_width(DEF_NUM_REGS);

endpackage

// File: rtl/regfile_wstage.sv
// regfile_wstage
//   One-entry write staging register and read-forwarding compare.
//   STORE=1: holds the staging entry (valid/addr/data) and compares against it.
//   STORE=0: compare only, against a staging entry supplied on src.
// Ports
//   clk, rst_n     : clock, synchronous active-low reset (store side)
//   load, flush    : capture laddr/ldata; drop the staged entry (store side)
//   laddr, ldata   : write address and data to stage
//   src            : external staging entry {valid, addr, data} (compare side)
//   raddr          : read address to compare against the staged entry
//   arr_data       : array contents at raddr
//   rdata          : forwarded or array read data
//   stg            : effective staging entry {valid, addr, data}
module regfile_wstage #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned AW     = 3,
    parameter bit          STORE  = 1'b1,
    localparam int unsigned SW    = 1 + AW + DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [AW-1:0]     laddr,
    input  logic [DATA_W-1:0] ldata,
    input  logic [SW-1:0]     src,
    input  logic [AW-1:0]     raddr,
    input  logic [DATA_W-1:0] arr_data,
    output logic [DATA_W-1:0] rdata,
    output logic [SW-1:0]     stg
);

    logic [SW-1:0] cur;

    if (STORE) begin : g_store
        logic              v;
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] d;

        // Valid lives exactly one cycle unless refreshed by a new write.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v <= 1'b0;
                a <= '0;
                d <= '0;
            end else if (flush) begin
                v <= 1'b0;
            end else if (load) begin
                v <= 1'b1;
                a <= laddr;
                d <= ldata;
            end else begin
                v <= 1'b0;
            end
        end

        assign cur = {v, a, d};

        logic unused_src;
        assign unused_src = ^src;
    end else begin : g_cmp
        assign cur = src;

        logic unused_store_pins;
        assign unused_store_pins = ^{clk, rst_n, load, flush, laddr, ldata};
    end

    assign stg = cur;

    always_comb begin
        rdata = arr_data;
        if (cur[SW-1] && (cur[DATA_W +: AW] == raddr)) begin
            rdata = cur[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/regfile_param.sv
// regfile_param
//   Parameterised register file with a one-cycle write staging stage,
//   read forwarding on two combinational read ports, write protection of
//   the upper address range, a sticky protection-error flag and a
//   saturating commit counter.
// Ports
//   clk, rst_n       : clock, synchronous active-low reset
//   we, waddr, wdata : write request
//   clr              : zero all writeable registers, drop staged write
//   err_clr          : clear sticky wr_err
//   raddr1, raddr2   : read addresses
//   rdata1, rdata2   : combinational read data (forwarded from staging)
//   wr_err           : sticky flag, write to protected address attempted
//   wr_count         : saturating count of writes committed to the array
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned WR_LIMIT = DEF_WR_LIMIT,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    localparam int unsigned AW      = addr_width(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    input  logic              err_clr,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              wr_err,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int unsigned SW = 1 + AW + DATA_W;
    // WR_LIMIT may equal NUM_REGS, so the compare needs one extra bit.
    localparam logic [AW:0] LIMIT = (AW+1)'(WR_LIMIT);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              writeable;
    logic              legal_wr;
    logic              bad_wr;
    logic [SW-1:0]     stg;
    logic              stg_valid;
    logic [AW-1:0]     stg_addr;
    logic [DATA_W-1:0] stg_data;
    logic              commit;

    logic [DATA_W-1:0] store_rdata_unused;
    logic [SW-1:0]     cmp1_stg_unused;
    logic [SW-1:0]     cmp2_stg_unused;

    assign writeable = ({1'b0, waddr} < LIMIT);
    assign legal_wr  = we && writeable && !clr;
    assign bad_wr    = we && !writeable && !clr;

    assign stg_valid = stg[SW-1];
    assign stg_addr  = stg[DATA_W +: AW];
    assign stg_data  = stg[DATA_W-1:0];

    // clr aborts a pending staged write as well as clearing the array.
    assign commit = stg_valid && !clr;

    regfile_wstage #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .STORE  (1'b1)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (legal_wr),
        .flush    (clr),
        .laddr    (waddr),
        .ldata    (wdata),
        .src      ('0),
        .raddr    ('0),
        .arr_data ('0),
        .rdata    (store_rdata_unused),
        .stg      (stg)
    );

    regfile_wstage #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .STORE  (1'b0)
    ) u_cmp1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .flush    (1'b0),
        .laddr    ('0),
        .ldata    ('0),
        .src      (stg),
        .raddr    (raddr1),
        .arr_data (regs[raddr1]),
        .rdata    (rdata1),
        .stg      (cmp1_stg_unused)
    );

    regfile_wstage #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .STORE  (1'b0)
    ) u_cmp2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .flush    (1'b0),
        .laddr    ('0),
        .ldata    ('0),
        .src      (stg),
        .raddr    (raddr2),
        .arr_data (regs[raddr2]),
        .rdata    (rdata2),
        .stg      (cmp2_stg_unused)
    );

    // Protected entries are only ever written by reset, so they read 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[AW'(i)] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < WR_LIMIT; i++) begin
                regs[AW'(i)] <= '0;
            end
        end else if (commit) begin
            regs[stg_addr] <= stg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else if (bad_wr) begin
            wr_err <= 1'b1;
        end else if (err_clr) begin
            wr_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (commit && (wr_count != '1)) begin
            wr_count <= wr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;
    import regfile_pkg::*;

    localparam int unsigned DW = DEF_DATA_W;
    localparam int unsigned AW = DEF_AW;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          clr;
    logic          err_clr;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          wr_err;
    logic [7:0]    wr_count;
    logic [DW-1:0] sat_rdata1;
    logic [DW-1:0] sat_rdata2;
    logic          sat_wr_err;
    logic [1:0]    sat_wr_count;

    int checks   = 0;
    int failures = 0;

    regfile_param dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .clr      (clr),
        .err_clr  (err_clr),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .wr_err   (wr_err),
        .wr_count (wr_count)
    );

    regfile_param #(
        .CNT_W (2)
    ) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .clr      (clr),
        .err_clr  (err_clr),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (sat_rdata1),
        .rdata2   (sat_rdata2),
        .wr_err   (sat_wr_err),
        .wr_count (sat_wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 1'b1; waddr = 1; wdata = 10'd77;
        clr = 1'b0; err_clr = 1'b0; raddr1 = '0; raddr2 = '0;
        step();
        step();
        rst_n = 1'b1; we = 1'b0;
        for (int i = 0; i < int'(DEF_NUM_REGS); i++) begin
            raddr1 = AW'(i);
            raddr2 = AW'(i);
            #1;
            checks++;
            if (rdata1 !== '0 || rdata2 !== '0) begin
                failures++;
                $display("FAIL reset_read[%0d]: got %0d/%0d expected 0/0", i, rdata1, rdata2);
            end
        end
        checks++;
        if (wr_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_wr_err: got %0b expected 0", wr_err);
        end
        checks++;
        if (wr_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_wr_count: got %0d expected 0", wr_count);
        end
    endtask

    task automatic test_write_forward();
        we = 1'b1; waddr = 1; wdata = 10'd55;
        step();
        we = 1'b0; raddr1 = 1;
        #1;
        checks++;
        if (rdata1 !== 10'd55) begin
            failures++;
            $display("FAIL fwd_read: got %0d expected 55", rdata1);
        end
        checks++;
        if (wr_count !== 8'd0) begin
            failures++;
            $display("FAIL fwd_count_before_commit: got %0d expected 0", wr_count);
        end
        step();
        checks++;
        if (rdata1 !== 10'd55 || wr_count !== 8'd1) begin
            failures++;
            $display("FAIL commit_read: got %0d cnt %0d expected 55 cnt 1", rdata1, wr_count);
        end
        step();
        checks++;
        if (rdata1 !== 10'd55 || wr_count !== 8'd1) begin
            failures++;
            $display("FAIL array_read: got %0d cnt %0d expected 55 cnt 1", rdata1, wr_count);
        end
    endtask

    task automatic test_protected();
        we = 1'b1; waddr = 4; wdata = 10'd100;
        step();
        we = 1'b0; raddr1 = 4; raddr2 = 7;
        #1;
        checks++;
        if (rdata1 !== '0 || rdata2 !== '0) begin
            failures++;
            $display("FAIL prot_read: got %0d/%0d expected 0/0", rdata1, rdata2);
        end
        checks++;
        if (wr_err !== 1'b1 || wr_count !== 8'd1) begin
            failures++;
            $display("FAIL prot_err: got err %0b cnt %0d expected err 1 cnt 1", wr_err, wr_count);
        end
        step();
        checks++;
        if (wr_err !== 1'b1 || rdata1 !== '0) begin
            failures++;
            $display("FAIL prot_sticky: got err %0b data %0d expected err 1 data 0", wr_err, rdata1);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (wr_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clr: got %0b expected 0", wr_err);
        end
    endtask

    task automatic test_back_to_back();
        we = 1'b1; waddr = 3; wdata = 10'd200;
        step();
        wdata = 10'd300; raddr1 = 3; raddr2 = 3;
        #1;
        checks++;
        if (rdata1 !== 10'd200 || rdata2 !== 10'd200) begin
            failures++;
            $display("FAIL b2b_first: got %0d/%0d expected 200/200", rdata1, rdata2);
        end
        step();
        we = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 10'd300 || rdata2 !== 10'd300) begin
            failures++;
            $display("FAIL b2b_second: got %0d/%0d expected 300/300", rdata1, rdata2);
        end
        step();
        step();
        checks++;
        if (rdata1 !== 10'd300 || rdata2 !== 10'd300 || wr_count !== 8'd3) begin
            failures++;
            $display("FAIL b2b_final: got %0d/%0d cnt %0d expected 300/300 cnt 3",
                     rdata1, rdata2, wr_count);
        end
    endtask

    task automatic test_clear();
        we = 1'b1; waddr = 0; wdata = 10'd7;
        step();
        we = 1'b0; clr = 1'b1; raddr1 = 0; raddr2 = 1;
        #1;
        checks++;
        if (rdata1 !== 10'd7) begin
            failures++;
            $display("FAIL clr_pre_fwd: got %0d expected 7", rdata1);
        end
        step();
        clr = 1'b0;
        checks++;
        if (rdata1 !== '0 || rdata2 !== '0 || wr_count !== 8'd3) begin
            failures++;
            $display("FAIL clr_abort: got %0d/%0d cnt %0d expected 0/0 cnt 3",
                     rdata1, rdata2, wr_count);
        end
        raddr2 = 3;
        #1;
        checks++;
        if (rdata2 !== '0) begin
            failures++;
            $display("FAIL clr_reg3: got %0d expected 0", rdata2);
        end
        we = 1'b1; waddr = 2; wdata = 10'd9; clr = 1'b1;
        step();
        we = 1'b0; clr = 1'b0; raddr1 = 2;
        #1;
        checks++;
        if (rdata1 !== '0) begin
            failures++;
            $display("FAIL clr_same_cycle: got %0d expected 0", rdata1);
        end
        step();
        checks++;
        if (rdata1 !== '0 || wr_count !== 8'd3) begin
            failures++;
            $display("FAIL clr_same_cycle_commit: got %0d cnt %0d expected 0 cnt 3", rdata1, wr_count);
        end
    endtask

    task automatic test_reset_mid();
        we = 1'b1; waddr = 5; wdata = 10'd1;
        step();
        waddr = 2; wdata = 10'd9; raddr1 = 2;
        #1;
        checks++;
        if (wr_err !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_err_set: got %0b expected 1", wr_err);
        end
        step();
        we = 1'b0; rst_n = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 10'd9) begin
            failures++;
            $display("FAIL rstmid_fwd: got %0d expected 9", rdata1);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < int'(DEF_NUM_REGS); i++) begin
            raddr1 = AW'(i);
            raddr2 = AW'(DEF_NUM_REGS - 1 - i);
            #1;
            checks++;
            if (rdata1 !== '0 || rdata2 !== '0) begin
                failures++;
                $display("FAIL rstmid_read[%0d]: got %0d/%0d expected 0/0", i, rdata1, rdata2);
            end
        end
        checks++;
        if (wr_count !== 8'd0 || wr_err !== 1'b0 || sat_wr_count !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_state: got cnt %0d err %0b satcnt %0d expected 0 0 0",
                     wr_count, wr_err, sat_wr_count);
        end
        step();
        raddr1 = 2;
        #1;
        checks++;
        if (rdata1 !== '0 || wr_count !== 8'd0) begin
            failures++;
            $display("FAIL rstmid_lost: got %0d cnt %0d expected 0 cnt 0", rdata1, wr_count);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_sat [6];
        exp_sat[0] = 2'd0; exp_sat[1] = 2'd1; exp_sat[2] = 2'd2;
        exp_sat[3] = 2'd3; exp_sat[4] = 2'd3; exp_sat[5] = 2'd3;
        for (int k = 0; k < 6; k++) begin
            we    = (k < 5);
            waddr = AW'(k % 4);
            wdata = DW'(k + 1);
            step();
            checks++;
            if (sat_wr_count !== exp_sat[k]) begin
                failures++;
                $display("FAIL sat_count[%0d]: got %0d expected %0d", k, sat_wr_count, exp_sat[k]);
            end
        end
        we = 1'b0;
        checks++;
        if (wr_count !== 8'd5) begin
            failures++;
            $display("FAIL nosat_count: got %0d expected 5", wr_count);
        end
        raddr1 = 0; raddr2 = 3;
        #1;
        checks++;
        if (sat_rdata1 !== 10'd5 || sat_rdata2 !== 10'd4) begin
            failures++;
            $display("FAIL sat_contents: got %0d/%0d expected 5/4", sat_rdata1, sat_rdata2);
        end
        we = 1'b1; waddr = 6; wdata = 10'd1; err_clr = 1'b1;
        step();
        we = 1'b0;
        checks++;
        if (wr_err !== 1'b1 || sat_wr_err !== 1'b1) begin
            failures++;
            $display("FAIL err_set_wins: got %0b/%0b expected 1/1", wr_err, sat_wr_err);
        end
        step();
        err_clr = 1'b0;
        checks++;
        if (wr_err !== 1'b0 || sat_wr_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clr_after: got %0b/%0b expected 0/0", wr_err, sat_wr_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_forward();
        test_protected();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
